// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data RAM between the MEM stage and a word-wide
// loader port. Round-robin arbitration, byte/half/word lane steering on stores, sign/zero
// extension on loads, and misalign/range/command error detection for the CPU side.
module dmem_arbiter #(
    parameter int unsigned DM_MEM_DEPTH = 4096,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned RAM_LATENCY  = 1,
    localparam int unsigned AW          = $clog2(DM_MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  cpu_rd,
    input  logic                  cpu_wr,
    input  logic [2:0]            cpu_func3,
    input  logic [31:0]           cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_ready,
    output logic                  cpu_err,
    input  logic                  ld_req,
    input  logic                  ld_we,
    input  logic [AW-1:0]         ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_wdata,
    output logic                  ld_gnt,
    output logic                  ld_rvalid,
    output logic [DATA_WIDTH-1:0] ld_rdata,
    output logic                  ram_en,
    output logic [3:0]            ram_we,
    output logic [AW-1:0]         ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    typedef enum logic [2:0] {
        Idle, CpuIssue, CpuWait, CpuDone, LdIssue, LdWait
    } arbStateT;

    localparam logic GrantLd  = 1'b0;
    localparam logic GrantCpu = 1'b1;

    arbStateT    stateQ;
    logic        lastGrantQ;
    logic [2:0]  waitCntQ;
    logic [1:0]  offQ;
    logic [2:0]  func3Q;
    logic        storeQ;
    logic        errQ;
    logic        ldWeQ;
    logic [31:0] cpuRdataQ;
    logic        cpuErrQ;
    logic        ldGntQ;
    logic        ldRvalidQ;
    logic [31:0] ldRdataQ;
    logic        ramEnQ;
    logic [3:0]  ramWeQ;
    logic [AW-1:0] ramAddrQ;
    logic [31:0] ramWdataQ;

    logic        cpuReq;
    logic        funcOk;
    logic        misalign;
    logic        outOfRange;
    logic        cpuErrNow;
    logic [3:0]  storeWe;
    logic [31:0] storeData;
    logic [31:0] laneData;
    logic [31:0] loadExt;
    logic        waitDone;

    assign cpuReq     = cpu_rd | cpu_wr;
    assign misalign   = (cpu_func3[1:0] == 2'b01 && cpu_addr[0]) ||
                        (cpu_func3[1:0] == 2'b10 && cpu_addr[1:0] != 2'b00);
    assign outOfRange = {2'b00, cpu_addr[31:2]} >= DM_MEM_DEPTH;
    assign cpuErrNow  = ~funcOk | misalign | outOfRange | (cpu_rd & cpu_wr);
    assign waitDone   = waitCntQ == 3'(RAM_LATENCY - 1);
    assign laneData   = ram_rdata >> {offQ, 3'b000};

    // Decode legal func3 encodings and build the lane-steered store strobe and data.
    always_comb begin
        funcOk    = 1'b0;
        storeWe   = 4'b1111;
        storeData = cpu_wdata;
        case (cpu_func3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: funcOk = 1'b1;
            default: funcOk = 1'b0;
        endcase
        case (cpu_func3[1:0])
            2'b00: begin
                storeWe   = 4'b0001 << cpu_addr[1:0];
                storeData = {4{cpu_wdata[7:0]}};
            end
            2'b01: begin
                storeWe   = 4'b0011 << cpu_addr[1:0];
                storeData = {2{cpu_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Pick the addressed lane of the returning word and extend it; func3[2] means unsigned.
    always_comb begin
        case (func3Q[1:0])
            2'b00:   loadExt = {{24{laneData[7] & ~func3Q[2]}}, laneData[7:0]};
            2'b01:   loadExt = {{16{laneData[15] & ~func3Q[2]}}, laneData[15:0]};
            default: loadExt = laneData;
        endcase
    end

    // Arbitration and access sequencing; every output is registered on the state transition.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            stateQ     <= Idle;
            lastGrantQ <= GrantLd;
            waitCntQ   <= '0;
            offQ       <= '0;
            func3Q     <= '0;
            storeQ     <= 1'b0;
            errQ       <= 1'b0;
            ldWeQ      <= 1'b0;
            cpuRdataQ  <= '0;
            cpuErrQ    <= 1'b0;
            ldGntQ     <= 1'b0;
            ldRvalidQ  <= 1'b0;
            ldRdataQ   <= '0;
            ramEnQ     <= 1'b0;
            ramWeQ     <= '0;
            ramAddrQ   <= '0;
            ramWdataQ  <= '0;
        end else begin
            ramEnQ    <= 1'b0;
            ramWeQ    <= '0;
            ldGntQ    <= 1'b0;
            ldRvalidQ <= 1'b0;
            cpuErrQ   <= 1'b0;
            case (stateQ)
                Idle: begin
                    if (cpuReq && (!ld_req || lastGrantQ == GrantLd)) begin
                        stateQ <= CpuIssue;
                        offQ   <= cpu_addr[1:0];
                        func3Q <= cpu_func3;
                        storeQ <= cpu_wr;
                        errQ   <= cpuErrNow;
                        if (!cpuErrNow) begin
                            ramEnQ   <= 1'b1;
                            ramAddrQ <= cpu_addr[AW+1:2];
                            if (cpu_wr) begin
                                ramWeQ    <= storeWe;
                                ramWdataQ <= storeData;
                            end
                        end
                    end else if (ld_req) begin
                        stateQ     <= LdIssue;
                        lastGrantQ <= GrantLd;
                        ldGntQ     <= 1'b1;
                        ldWeQ      <= ld_we;
                        ramEnQ     <= 1'b1;
                        ramAddrQ   <= ld_addr;
                        ramWeQ     <= ld_we ? 4'b1111 : 4'b0000;
                        ramWdataQ  <= ld_wdata;
                    end
                end
                CpuIssue: begin
                    if (errQ) begin
                        stateQ    <= CpuDone;
                        cpuErrQ   <= 1'b1;
                        cpuRdataQ <= '0;
                    end else if (storeQ) begin
                        stateQ <= CpuDone;
                    end else begin
                        stateQ   <= CpuWait;
                        waitCntQ <= '0;
                    end
                end
                CpuWait: begin
                    if (waitDone) begin
                        stateQ    <= CpuDone;
                        cpuRdataQ <= loadExt;
                    end else begin
                        waitCntQ <= waitCntQ + 3'd1;
                    end
                end
                CpuDone: begin
                    stateQ     <= Idle;
                    lastGrantQ <= GrantCpu;
                end
                LdIssue: begin
                    if (ldWeQ) begin
                        stateQ <= Idle;
                    end else begin
                        stateQ   <= LdWait;
                        waitCntQ <= '0;
                    end
                end
                LdWait: begin
                    if (waitDone) begin
                        stateQ    <= Idle;
                        ldRdataQ  <= ram_rdata;
                        ldRvalidQ <= 1'b1;
                    end else begin
                        waitCntQ <= waitCntQ + 3'd1;
                    end
                end
                default: stateQ <= Idle;
            endcase
        end
    end

    // Ready is high when idle with nothing pending, or for the single completion cycle.
    assign cpu_ready = (stateQ == CpuDone) || (stateQ == Idle && !cpuReq);
    assign cpu_rdata = cpuRdataQ;
    assign cpu_err   = cpuErrQ;
    assign ld_gnt    = ldGntQ;
    assign ld_rvalid = ldRvalidQ;
    assign ld_rdata  = ldRdataQ;
    assign ram_en    = ramEnQ;
    assign ram_we    = ramWeQ;
    assign ram_addr  = ramAddrQ;
    assign ram_wdata = ramWdataQ;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: bench-side RAM with RAM_LATENCY pipeline, a shadow-memory
// model of the CPU/loader semantics, and one negedge compare process.
module tb_dmem_arbiter;

    localparam int unsigned DEPTH = 4096;
    localparam int unsigned LAT   = 3;
    localparam int unsigned AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rstN;
    logic          cpu_rd, cpu_wr;
    logic [2:0]    cpu_func3;
    logic [31:0]   cpu_addr, cpu_wdata, cpu_rdata;
    logic          cpu_ready, cpu_err;
    logic          ld_req, ld_we;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_wdata, ld_rdata;
    logic          ld_gnt, ld_rvalid;
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata, ram_rdata;

    dmem_arbiter #(
        .DM_MEM_DEPTH(DEPTH),
        .DATA_WIDTH  (32),
        .RAM_LATENCY (LAT)
    ) dut (
        .clk      (clk),
        .rstN     (rstN),
        .cpu_rd   (cpu_rd),
        .cpu_wr   (cpu_wr),
        .cpu_func3(cpu_func3),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .cpu_ready(cpu_ready),
        .cpu_err  (cpu_err),
        .ld_req   (ld_req),
        .ld_we    (ld_we),
        .ld_addr  (ld_addr),
        .ld_wdata (ld_wdata),
        .ld_gnt   (ld_gnt),
        .ld_rvalid(ld_rvalid),
        .ld_rdata (ld_rdata),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bench RAM: byte-enabled writes, reads returned LAT cycles after the strobe.
    logic        ramInit;
    logic [31:0] mem [DEPTH];
    logic [31:0] rdPipe [LAT];
    assign ram_rdata = rdPipe[LAT-1];

    always @(posedge clk) begin
        if (ramInit) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            for (int i = 0; i < LAT; i++) rdPipe[i] <= 32'hA5A5_A5A5;
        end else begin
            if (ram_en) begin
                for (int b = 0; b < 4; b++)
                    if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
            for (int i = LAT - 1; i > 0; i--) rdPipe[i] <= rdPipe[i-1];
            rdPipe[0] <= (ram_en && ram_we == 4'b0000) ? mem[ram_addr] : 32'hA5A5_A5A5;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Shadow memory holding what the data RAM must contain.
    logic [31:0] shadow [DEPTH];

    function automatic bit modelErr(input bit rd, input bit wr, input logic [2:0] f3,
                                    input logic [31:0] a);
        bit bad = rd && wr;
        case (f3)
            3'd0, 3'd4: ;
            3'd1, 3'd5: if (a % 2 != 0) bad = 1'b1;
            3'd2:       if (a % 4 != 0) bad = 1'b1;
            default:    bad = 1'b1;
        endcase
        if (a / 4 >= DEPTH) bad = 1'b1;
        return bad;
    endfunction

    function automatic int accessBytes(input logic [2:0] f3);
        return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [3:0] storeMask(input logic [2:0] f3, input logic [31:0] a);
        int n = accessBytes(f3);
        int base = (n == 4) ? 0 : int'(a % 4);
        return 4'(((1 << n) - 1) << base);
    endfunction

    function automatic void modelStore(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] d);
        int n = accessBytes(f3);
        int base = (n == 4) ? 0 : int'(a % 4);
        for (int k = 0; k < n; k++) shadow[a / 4][8*(base+k) +: 8] = d[8*k +: 8];
    endfunction

    function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v;
        v = shadow[a / 4] >> (8 * (a % 4));
        case (f3)
            3'd0: begin v = v & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFF_FF00; end
            3'd4: v = v & 32'hFF;
            3'd1: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF_0000; end
            3'd5: v = v & 32'hFFFF;
            default: ;
        endcase
        return v;
    endfunction

    // Expectations shared between drivers and the compare process.
    bit            cpuActive = 1'b0;
    int            cpuStart, cpuExpLat, cpuRamEns;
    bit            cpuExpErr, cpuChkData;
    logic [31:0]   cpuExpData;
    logic [3:0]    cpuExpWe;
    logic [AW-1:0] cpuExpAddr;
    logic [31:0]   lastRdata;
    logic [3:0]    lastWe;
    logic [AW-1:0] lastAddr;
    bit            lastErr;
    bit            ldActive = 1'b0;
    int            ldStart, ldExpLat;
    bit            ldExpWe;
    logic [AW-1:0] ldExpAddr;
    logic [31:0]   ldExpData;
    logic [31:0]   rvData [$];
    int            rvCyc [$];

    // Single compare process, sampling away from the active edge.
    always @(negedge clk) begin
        if (rstN) begin
            if (cpu_err) check("err without ready", 32'(cpu_ready), 32'd1);
            if (ram_en && !ld_gnt && cpuActive) begin
                cpuRamEns++;
                lastWe   = ram_we;
                lastAddr = ram_addr;
                check("cpu ram_we", 32'(ram_we), 32'(cpuExpWe));
                check("cpu ram_addr", 32'(ram_addr), 32'(cpuExpAddr));
            end
            if (cpuActive && cpu_ready) begin
                check("cpu latency", 32'(cyc - cpuStart + 1), 32'(cpuExpLat));
                check("cpu err", 32'(cpu_err), 32'(cpuExpErr));
                check("cpu ram strobes", 32'(cpuRamEns), cpuExpErr ? 32'd0 : 32'd1);
                if (cpuChkData) check("cpu rdata", cpu_rdata, cpuExpData);
                lastRdata = cpu_rdata;
                lastErr   = cpu_err;
                cpuActive = 1'b0;
            end
            if (ld_gnt) begin
                if (ldActive) begin
                    check("ld gnt latency", 32'(cyc - ldStart), 32'(ldExpLat));
                    check("ld ram_en", 32'(ram_en), 32'd1);
                    check("ld ram_we", 32'(ram_we), ldExpWe ? 32'hF : 32'h0);
                    check("ld ram_addr", 32'(ram_addr), 32'(ldExpAddr));
                    if (!ldExpWe) begin
                        rvData.push_back(ldExpData);
                        rvCyc.push_back(cyc);
                    end
                    ldActive = 1'b0;
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL ld_gnt unrequested: got 1 expected 0 (cycle %0d)", cyc);
                end
            end
            if (ld_rvalid) begin
                if (rvData.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ld_rvalid unexpected: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    check("ld rdata", ld_rdata, rvData[0]);
                    check("ld rvalid latency", 32'(cyc - rvCyc[0]), 32'(LAT + 1));
                    void'(rvData.pop_front());
                    void'(rvCyc.pop_front());
                end
            end
        end
    end

    task automatic cpuOp(input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input int expLat);
        int n = 0;
        @(posedge clk);
        #1;
        cpuExpErr  = modelErr(rd, wr, f3, addr);
        cpuChkData = rd || cpuExpErr;
        cpuExpData = cpuExpErr ? 32'h0 : (rd ? modelLoad(f3, addr) : 32'h0);
        cpuExpAddr = AW'(addr >> 2);
        cpuExpWe   = wr ? storeMask(f3, addr) : 4'h0;
        if (wr && !cpuExpErr) modelStore(f3, addr, wdata);
        cpuExpLat  = expLat;
        cpuRamEns  = 0;
        cpuStart   = cyc;
        cpuActive  = 1'b1;
        cpu_rd = rd; cpu_wr = wr; cpu_func3 = f3; cpu_addr = addr; cpu_wdata = wdata;
        while (cpuActive && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        if (cpuActive) begin
            checks++;
            errors++;
            $display("FAIL cpu timeout: got no ready expected ready by %0d cycles", expLat);
            cpuActive = 1'b0;
        end
    endtask

    task automatic ldOp(input bit we, input int addr, input logic [31:0] data, input int expLat);
        int n = 0;
        @(posedge clk);
        #1;
        ldExpWe   = we;
        ldExpAddr = AW'(addr);
        ldExpData = shadow[addr];
        if (we) shadow[addr] = data;
        ldExpLat  = expLat;
        ldStart   = cyc;
        ldActive  = 1'b1;
        ld_req = 1'b1; ld_we = we; ld_addr = AW'(addr); ld_wdata = data;
        while (ldActive && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        ld_req = 1'b0;
        if (ldActive) begin
            checks++;
            errors++;
            $display("FAIL ld timeout: got no gnt expected gnt by %0d cycles", expLat);
            ldActive = 1'b0;
        end
        n = 0;
        while (rvData.size() > 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        if (rvData.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL ld rvalid timeout: got none expected %0d", rvData.size());
            rvData.delete();
            rvCyc.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstN = 1'b0; ramInit = 1'b1;
        cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_func3 = '0; cpu_addr = '0; cpu_wdata = '0;
        ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset cpu_ready", 32'(cpu_ready), 32'd1);
        check("reset cpu_err", 32'(cpu_err), 32'd0);
        check("reset cpu_rdata", cpu_rdata, 32'd0);
        check("reset ram_en", 32'(ram_en), 32'd0);
        check("reset ram_we", 32'(ram_we), 32'd0);
        check("reset ld_gnt", 32'(ld_gnt), 32'd0);
        check("reset ld_rvalid", 32'(ld_rvalid), 32'd0);
        check("reset ld_rdata", ld_rdata, 32'd0);
        rstN = 1'b1; ramInit = 1'b0;

        // Same-cycle contention out of reset: CPU wins, loader granted 4 cycles later.
        fork
            cpuOp(1'b0, 1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 3);
            ldOp(1'b1, 7, 32'h0000_1234, 4);
        join
        check("SW ram_we", 32'(lastWe), 32'hF);
        check("SW ram_addr", 32'(lastAddr), 32'd4);

        cpuOp(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, 6);
        check("LW data", lastRdata, 32'hDEAD_BEEF);
        check("LW err", 32'(lastErr), 32'd0);

        // CPU was granted last, so the loader read goes first and delays the CPU.
        fork
            cpuOp(1'b1, 1'b0, 3'd2, 32'h1C, 32'h0, 11);
            ldOp(1'b0, 4, 32'h0, 1);
        join
        check("LW after loader", lastRdata, 32'h0000_1234);

        for (int i = 0; i < 16; i++) ldOp(1'b1, i, 32'(i * 3), 1);
        for (int i = 0; i < 16; i++) begin
            cpuOp(1'b1, 1'b0, 3'd2, 32'(i * 4), 32'h0, 6);
            check("fill readback", lastRdata, 32'(i * 3));
        end

        cpuOp(1'b0, 1'b1, 3'd0, 32'h13, 32'h0000_0080, 3);
        check("SB ram_we", 32'(lastWe), 32'h8);
        cpuOp(1'b1, 1'b0, 3'd0, 32'h13, 32'h0, 6);
        check("LB sign", lastRdata, 32'hFFFF_FF80);
        cpuOp(1'b1, 1'b0, 3'd4, 32'h13, 32'h0, 6);
        check("LBU zero", lastRdata, 32'h0000_0080);

        cpuOp(1'b1, 1'b0, 3'd1, 32'h11, 32'h0, 3);
        check("LH misalign err", 32'(lastErr), 32'd1);
        check("LH misalign rdata", lastRdata, 32'd0);

        cpuOp(1'b0, 1'b1, 3'd1, 32'h22, 32'h1234_BEEF, 3);
        check("SH ram_we", 32'(lastWe), 32'hC);
        cpuOp(1'b1, 1'b0, 3'd1, 32'h22, 32'h0, 6);
        check("LH sign", lastRdata, 32'hFFFF_BEEF);
        cpuOp(1'b1, 1'b0, 3'd5, 32'h22, 32'h0, 6);
        check("LHU zero", lastRdata, 32'h0000_BEEF);
        cpuOp(1'b1, 1'b0, 3'd2, 32'h21, 32'h0, 3);
        cpuOp(1'b1, 1'b0, 3'd2, 32'h4000, 32'h0, 3);
        cpuOp(1'b0, 1'b1, 3'd2, 32'h4000, 32'h1, 3);
        cpuOp(1'b1, 1'b0, 3'd3, 32'h0, 32'h0, 3);
        cpuOp(1'b1, 1'b1, 3'd2, 32'h0, 32'h0, 3);
        check("rd&wr err", 32'(lastErr), 32'd1);
        cpuOp(1'b1, 1'b0, 3'd2, 32'h20, 32'h0, 6);
        check("LW after SH", lastRdata, 32'hBEEF_0018);

        ldOp(1'b0, 4, 32'h0, 1);
        ldOp(1'b0, 8, 32'h0, 1);
        check("ld_rdata word 8", ld_rdata, 32'hBEEF_0018);

        // Reset while a load sits in CPU_WAIT; the late RAM word must not surface.
        @(posedge clk); #1;
        cpu_rd = 1'b1; cpu_func3 = 3'd2; cpu_addr = 32'h8;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstN = 1'b0;
        cpu_rd = 1'b0;
        @(negedge clk);
        check("mid reset cpu_rdata", cpu_rdata, 32'd0);
        check("mid reset cpu_ready", 32'(cpu_ready), 32'd1);
        check("mid reset cpu_err", 32'(cpu_err), 32'd0);
        check("mid reset ram_en", 32'(ram_en), 32'd0);
        rstN = 1'b1;
        for (int i = 0; i < LAT + 2; i++) begin
            @(negedge clk);
            check("stale rdata", cpu_rdata, 32'd0);
            check("post reset ready", 32'(cpu_ready), 32'd1);
        end
        cpuOp(1'b1, 1'b0, 3'd2, 32'h8, 32'h0, 6);
        check("recover LW", lastRdata, 32'd6);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
